// File: rtl/mwp_write_arbiter_if.sv
// Request/grant and RAM write-port bundle for mwp_write_arbiter.
// The slave modport is the arbiter side; the master modport is the requester/RAM side.
interface mwp_write_arbiter_if #(
  parameter int NUM_REQ         = 4,
  parameter int NUM_WRITE_PORTS = 2,
  parameter int ADDR_WIDTH      = 5,
  parameter int DATA_WIDTH      = 32
);
  logic                                         i_flush;
  logic [NUM_REQ-1:0]                           i_req_valid;
  logic [NUM_REQ-1:0]                           o_req_ready;
  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]           i_req_address;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]           i_req_data;
  logic [NUM_WRITE_PORTS-1:0]                   o_write_enable;
  logic [NUM_WRITE_PORTS-1:0][ADDR_WIDTH-1:0]   o_write_address;
  logic [NUM_WRITE_PORTS-1:0][DATA_WIDTH-1:0]   o_write_data;
  logic                                         o_init_done;

  modport slave (
    input  i_flush, i_req_valid, i_req_address, i_req_data,
    output o_req_ready, o_write_enable, o_write_address, o_write_data, o_init_done
  );

  modport master (
    output i_flush, i_req_valid, i_req_address, i_req_data,
    input  o_req_ready, o_write_enable, o_write_address, o_write_data, o_init_done
  );
endinterface

// File: rtl/mwp_write_arbiter.sv
// Front end for a multi-write-port RAM: fills every entry with INIT_VALUE after reset/flush,
// then shares the write ports among valid/ready requesters with rotating priority.
module mwp_write_arbiter #(
  parameter int                    NUM_REQ         = 4,
  parameter int                    NUM_WRITE_PORTS = 2,
  parameter int                    ADDR_WIDTH      = 5,
  parameter int                    DATA_WIDTH      = 32,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE      = '0
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  mwp_write_arbiter_if.slave    bus
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int CNT_W = $clog2(DEPTH + 2 * NUM_WRITE_PORTS) + 1;
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] STEP_C  = CNT_W'(NUM_WRITE_PORTS);

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_e;

  state_e                                     state_q, state_d;
  logic [CNT_W-1:0]                           cnt_q, cnt_d;
  logic [PTR_W-1:0]                           ptr_q, ptr_d;
  logic [NUM_WRITE_PORTS-1:0]                 write_enable_q, write_enable_d;
  logic [NUM_WRITE_PORTS-1:0][ADDR_WIDTH-1:0] write_address_q, write_address_d;
  logic [NUM_WRITE_PORTS-1:0][DATA_WIDTH-1:0] write_data_q, write_data_d;
  logic                                       init_done_q, init_done_d;
  logic [NUM_REQ-1:0]                         req_ready;

  int idx;
  int port;
  int n_granted;
  int last_idx;

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path can infer a latch.
    state_d         = state_q;
    cnt_d           = cnt_q;
    ptr_d           = ptr_q;
    write_enable_d  = '0;
    write_address_d = write_address_q;
    write_data_d    = write_data_q;
    init_done_d     = (state_q == ST_RUN) && !bus.i_flush;
    req_ready       = '0;
    idx             = 0;
    port            = 0;
    n_granted       = 0;
    last_idx        = 0;

    case (state_q)
      ST_INIT: begin
        // Slots past the end of the RAM are presented with their enable low.
        for (int wp = 0; wp < NUM_WRITE_PORTS; wp++) begin
          write_enable_d[wp]  = (cnt_q + CNT_W'(wp)) < DEPTH_C;
          write_address_d[wp] = ADDR_WIDTH'(cnt_q + CNT_W'(wp));
          write_data_d[wp]    = INIT_VALUE;
        end
        cnt_d = cnt_q + STEP_C;
        if (cnt_d >= DEPTH_C) begin
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        // Highest-priority grant lands on the highest-numbered port, which wins RAM collisions.
        for (int i = 0; i < NUM_REQ; i++) begin
          idx = int'(ptr_q) + i;
          if (idx >= NUM_REQ) begin
            idx = idx - NUM_REQ;
          end
          if (bus.i_req_valid[idx] && (n_granted < NUM_WRITE_PORTS)) begin
            port                  = NUM_WRITE_PORTS - 1 - n_granted;
            req_ready[idx]        = 1'b1;
            write_enable_d[port]  = 1'b1;
            write_address_d[port] = bus.i_req_address[idx];
            write_data_d[port]    = bus.i_req_data[idx];
            last_idx              = idx;
            n_granted             = n_granted + 1;
          end
        end
        if (n_granted > 0) begin
          ptr_d = (last_idx == NUM_REQ - 1) ? '0 : PTR_W'(last_idx + 1);
        end
      end

      default: begin
        state_d = ST_INIT;
      end
    endcase

    if (bus.i_flush) begin
      state_d = ST_INIT;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q         <= ST_INIT;
      cnt_q           <= '0;
      ptr_q           <= '0;
      write_enable_q  <= '0;
      write_address_q <= '0;
      write_data_q    <= '0;
      init_done_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      ptr_q           <= ptr_d;
      write_enable_q  <= write_enable_d;
      write_address_q <= write_address_d;
      write_data_q    <= write_data_d;
      init_done_q     <= init_done_d;
    end
  end

  assign bus.o_req_ready     = req_ready;
  assign bus.o_write_enable  = write_enable_q;
  assign bus.o_write_address = write_address_q;
  assign bus.o_write_data    = write_data_q;
  assign bus.o_init_done     = init_done_q;

endmodule

// File: tb/tb_mwp_write_arbiter.sv
// Directed bench for mwp_write_arbiter: init sweep (2 and 3 ports), round-robin,
// collision via a small RAM model, sparse/idle pointer behaviour, flush and async reset.
module tb_mwp_write_arbiter;

  localparam int              NR     = 4;
  localparam int              NWP    = 2;
  localparam int              AW     = 5;
  localparam int              DW     = 32;
  localparam logic [DW-1:0]   INIT_V = 32'hC0DE_0001;
  localparam logic [DW-1:0]   DATA_A = 32'h0000_000A;
  localparam logic [DW-1:0]   DATA_B = 32'h0000_000B;

  logic i_clk = 1'b0;
  logic i_rst_n;

  always #5 i_clk = ~i_clk;

  mwp_write_arbiter_if #(.NUM_REQ(NR), .NUM_WRITE_PORTS(NWP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
  mwp_write_arbiter_if #(.NUM_REQ(NR), .NUM_WRITE_PORTS(3),   .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus3 ();

  mwp_write_arbiter #(
    .NUM_REQ(NR), .NUM_WRITE_PORTS(NWP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INIT_VALUE(INIT_V)
  ) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus)
  );

  mwp_write_arbiter #(
    .NUM_REQ(NR), .NUM_WRITE_PORTS(3), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INIT_VALUE(INIT_V)
  ) dut3 (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus3)
  );

  int checks   = 0;
  int failures = 0;

  // RAM model: later (higher-numbered) ports overwrite earlier ones on the same address.
  logic [DW-1:0] ram [2**AW];
  always @(posedge i_clk) begin
    for (int wp = 0; wp < NWP; wp++) begin
      if (bus.o_write_enable[wp]) ram[bus.o_write_address[wp]] <= bus.o_write_data[wp];
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_port(input string tag, input int wp, input logic [AW-1:0] a, input logic [DW-1:0] d);
    check({tag, "_addr"}, 64'(bus.o_write_address[wp]), 64'(a));
    check({tag, "_data"}, 64'(bus.o_write_data[wp]), 64'(d));
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive(input logic [NR-1:0] valid, input logic flush);
    bus.i_req_valid = valid;
    bus.i_flush     = flush;
    #1;
  endtask

  // Starts in the first INIT cycle; ends one cycle after the state reaches RUN.
  task automatic run_init(input bit chk3);
    for (int k = 1; k <= 16; k++) begin
      drive('1, 1'b0);
      check("init_ready", 64'(bus.o_req_ready), 64'(0));
      tick();
      check("init_en", 64'(bus.o_write_enable), 64'(2'b11));
      check_port("init_p0", 0, AW'(2 * (k - 1)), INIT_V);
      check_port("init_p1", 1, AW'(2 * (k - 1) + 1), INIT_V);
      check("init_done_low", 64'(bus.o_init_done), 64'(0));
      if (chk3 && k == 11) begin
        check("init3_en", 64'(bus3.o_write_enable), 64'(3'b011));
        check("init3_a0", 64'(bus3.o_write_address[0]), 64'(30));
        check("init3_a1", 64'(bus3.o_write_address[1]), 64'(31));
        check("init3_done_low", 64'(bus3.o_init_done), 64'(0));
      end
      if (chk3 && k == 12) begin
        check("init3_en_run", 64'(bus3.o_write_enable), 64'(0));
        check("init3_done", 64'(bus3.o_init_done), 64'(1));
      end
    end
    bus.i_req_valid = '0;
    tick();
    check("init_done_high", 64'(bus.o_init_done), 64'(1));
    check("run_idle_en", 64'(bus.o_write_enable), 64'(0));
  endtask

  initial begin
    i_rst_n          = 1'b0;
    bus.i_flush      = 1'b0;
    bus.i_req_valid  = '1;
    for (int r = 0; r < NR; r++) begin
      bus.i_req_address[r] = AW'(10 + r);
      bus.i_req_data[r]    = 32'h100 + r;
    end
    bus3.i_flush       = 1'b0;
    bus3.i_req_valid   = '0;
    bus3.i_req_address = '0;
    bus3.i_req_data    = '0;

    // Reset state
    repeat (2) @(posedge i_clk);
    #1;
    check("rst_en", 64'(bus.o_write_enable), 64'(0));
    check("rst_addr", 64'(bus.o_write_address), 64'(0));
    check("rst_data", 64'(bus.o_write_data), 64'(0));
    check("rst_done", 64'(bus.o_init_done), 64'(0));
    check("rst_ready", 64'(bus.o_req_ready), 64'(0));
    i_rst_n = 1'b1;

    run_init(1'b1);

    // Round-robin with every requester valid
    drive(4'b1111, 1'b0);
    check("rr0_ready", 64'(bus.o_req_ready), 64'(4'b0011));
    tick();
    check("rr0_en", 64'(bus.o_write_enable), 64'(2'b11));
    check_port("rr0_p1", 1, AW'(10), 32'h100);
    check_port("rr0_p0", 0, AW'(11), 32'h101);
    #1;
    check("rr1_ready", 64'(bus.o_req_ready), 64'(4'b1100));
    tick();
    check_port("rr1_p1", 1, AW'(12), 32'h102);
    check_port("rr1_p0", 0, AW'(13), 32'h103);
    #1;
    check("rr2_ready", 64'(bus.o_req_ready), 64'(4'b0011));
    tick();
    check_port("rr2_p1", 1, AW'(10), 32'h100);
    check_port("rr2_p0", 0, AW'(11), 32'h101);
    #1;
    check("rr3_ready", 64'(bus.o_req_ready), 64'(4'b1100));
    tick();

    // Collision on address 5 with ptr=0
    bus.i_req_address[0] = AW'(5);
    bus.i_req_data[0]    = DATA_A;
    bus.i_req_address[2] = AW'(5);
    bus.i_req_data[2]    = DATA_B;
    drive(4'b0101, 1'b0);
    check("col_ready", 64'(bus.o_req_ready), 64'(4'b0101));
    tick();
    check("col_en", 64'(bus.o_write_enable), 64'(2'b11));
    check_port("col_p1", 1, AW'(5), DATA_A);
    check_port("col_p0", 0, AW'(5), DATA_B);

    // Idle cycle: no grants, ptr stays at 3, unused ports hold
    drive('0, 1'b0);
    check("idle_ready", 64'(bus.o_req_ready), 64'(0));
    tick();
    check("idle_en", 64'(bus.o_write_enable), 64'(0));
    check_port("idle_hold_p1", 1, AW'(5), DATA_A);
    check("col_ram", 64'(ram[5]), 64'(DATA_A));

    drive(4'b1001, 1'b0);
    check("wrap_ready", 64'(bus.o_req_ready), 64'(4'b1001));
    tick();
    check("wrap_en", 64'(bus.o_write_enable), 64'(2'b11));
    check_port("wrap_p1", 1, AW'(13), 32'h103);
    check_port("wrap_p0", 0, AW'(5), DATA_A);

    // Sparse: only req3 valid
    drive(4'b1000, 1'b0);
    check("sparse0_ready", 64'(bus.o_req_ready), 64'(4'b1000));
    tick();
    check("sparse0_en", 64'(bus.o_write_enable), 64'(2'b10));
    check_port("sparse0_p1", 1, AW'(13), 32'h103);
    check_port("sparse0_p0_hold", 0, AW'(5), DATA_A);
    drive(4'b1000, 1'b0);
    check("sparse1_ready", 64'(bus.o_req_ready), 64'(4'b1000));
    tick();
    check("sparse1_en", 64'(bus.o_write_enable), 64'(2'b10));
    drive(4'b1111, 1'b0);
    check("ptr_wrapped_ready", 64'(bus.o_req_ready), 64'(4'b0011));

    // Flush in RUN with req1 granted
    drive(4'b0010, 1'b1);
    check("flush_ready", 64'(bus.o_req_ready), 64'(4'b0010));
    tick();
    bus.i_flush = 1'b0;
    check("flush_en", 64'(bus.o_write_enable), 64'(2'b10));
    check_port("flush_p1", 1, AW'(11), 32'h101);
    check("flush_done", 64'(bus.o_init_done), 64'(0));
    run_init(1'b0);

    // Async reset mid-INIT at cnt=8
    drive('0, 1'b1);
    tick();
    bus.i_flush = 1'b0;
    check("flush2_en", 64'(bus.o_write_enable), 64'(0));
    check("flush2_done", 64'(bus.o_init_done), 64'(0));
    repeat (4) tick();
    check_port("mid_p0", 0, AW'(6), INIT_V);
    #3;
    i_rst_n = 1'b0;
    bus.i_req_valid = '1;
    #1;
    check("arst_en", 64'(bus.o_write_enable), 64'(0));
    check("arst_addr", 64'(bus.o_write_address), 64'(0));
    check("arst_data", 64'(bus.o_write_data), 64'(0));
    check("arst_ready", 64'(bus.o_req_ready), 64'(0));
    @(negedge i_clk);
    i_rst_n = 1'b1;
    tick();
    check("rel_en", 64'(bus.o_write_enable), 64'(2'b11));
    check_port("rel_p0", 0, AW'(0), INIT_V);
    check_port("rel_p1", 1, AW'(1), INIT_V);
    tick();
    check_port("rel2_p0", 0, AW'(2), INIT_V);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mwp_write_arbiter.md
Name: mwp_write_arbiter

Overview:
- Front-end controller for a multi-write-port distributed RAM (NUM_WRITE_PORTS write ports, one LVT-steered read port).
- After reset, and after each flush, it initialises every RAM entry to INIT_VALUE.
- It then shares the write ports among NUM_REQ valid/ready requesters with rotating priority, granting up to NUM_WRITE_PORTS requests per cycle.
- Its outputs drive the RAM write ports directly and are registered.

Parameters:
- NUM_REQ, 4, number of requesters (>= NUM_WRITE_PORTS).
- NUM_WRITE_PORTS, 2, RAM write ports (>= 2).
- ADDR_WIDTH, 5, RAM address width; Depth = 2**ADDR_WIDTH.
- DATA_WIDTH, 32, data width.
- INIT_VALUE, '0, DATA_WIDTH-wide value written to every entry during INIT.

Ports:
- i_clk, input, 1, clock; all logic on the rising edge.
- i_rst_n, input, 1, reset; asynchronous assert, active-low.
- i_flush, input, 1, single-cycle pulse that restarts INIT.
- i_req_valid, input, [NUM_REQ], request valid per requester.
- o_req_ready, output, [NUM_REQ], grant per requester; combinational from i_req_valid, state and pointer.
- i_req_address, input, [NUM_REQ][ADDR_WIDTH], request address.
- i_req_data, input, [NUM_REQ][DATA_WIDTH], request data.
- o_write_enable, output, [NUM_WRITE_PORTS], to RAM i_write_enable; registered.
- o_write_address, output, [NUM_WRITE_PORTS][ADDR_WIDTH], to RAM; registered.
- o_write_data, output, [NUM_WRITE_PORTS][DATA_WIDTH], to RAM; registered.
- o_init_done, output, 1, high while in RUN; registered.

Behaviour:
- Reset (i_rst_n=0, asynchronous):
  - State INIT, init counter 0, priority pointer 0.
  - o_write_enable, o_write_address, o_write_data all 0; o_init_done 0; o_req_ready 0.
  - Any in-flight initialisation is abandoned; it restarts from address 0 after reset release.
- INIT state:
  - o_req_ready is all 0.
  - Each cycle, port wp writes address cnt+wp with INIT_VALUE.
  - A port whose address is >= Depth has enable 0 that cycle.
  - cnt advances by NUM_WRITE_PORTS per cycle.
  - INIT takes ceil(Depth/NUM_WRITE_PORTS) cycles, then moves to RUN.
  - o_init_done rises in the cycle after the last INIT write is presented on the outputs.
- RUN state, grant selection:
  - Scan requesters in order ptr, ptr+1, ... mod NUM_REQ.
  - The first NUM_WRITE_PORTS requesters with valid=1 get ready=1; all others get ready=0.
  - A handshake occurs when valid and ready are both 1.
- RUN state, port mapping:
  - The k-th granted requester in scan order (k=0 first) drives port NUM_WRITE_PORTS-1-k.
  - Consequence: on a same-cycle same-address collision, the requester with the highest scan priority wins, because the RAM's highest-numbered port wins.
  - Unused ports have enable 0; their address and data are don't-care and hold their previous values.
- Latency: a handshake in cycle N appears on the o_write_* outputs in cycle N+1. The RAM commits at the end of N+1, and the data is readable from cycle N+2.
- Pointer update:
  - If at least one grant was made: ptr <= (index of last granted requester + 1) mod NUM_REQ.
  - If no grant was made: ptr is unchanged.
  - ptr is not changed during INIT.
- i_flush:
  - Sampled in any state.
  - Next cycle: state INIT, cnt 0, o_init_done 0.
  - Requests granted in the flush cycle are still written in the following cycle. INIT writes begin the cycle after those.
  - A flush during INIT restarts at address 0.
  - ptr is not reset by flush.
- Requester contract: a requester must hold its address and data stable while valid and not ready. The arbiter has no internal request buffering.

Test Plan:
- Init length, NUM_WRITE_PORTS=2, ADDR_WIDTH=5: release reset -> 16 INIT cycles writing address pairs (0,1), (2,3) ... (30,31) with INIT_VALUE; o_init_done=1 from cycle 17; all ready=0 throughout INIT.
- Init, non-multiple depth, NUM_WRITE_PORTS=3, Depth=32: -> 11 INIT cycles; the last cycle has port0=30, port1=31, port2 enable 0.
- Round-robin, NUM_REQ=4, NUM_WRITE_PORTS=2, all valid held high: grants {0,1}, {2,3}, {0,1}; req0 always on port1 and req1 on port0 in its grant cycle.
- Collision, ptr=0: req0 writes addr 5 = 0xA and req2 writes addr 5 = 0xB in the same cycle -> req0 on port1, req2 on port0; the RAM reads 0xA at addr 5 two cycles later.
- Sparse: only req3 valid with ptr=0 -> req3 granted on port1, port0 enable 0, ptr becomes 0; no requests valid -> ptr unchanged.
- Flush and reset: flush in RUN with req1 granted -> req1's write appears next cycle, then 16 INIT cycles. Async reset asserted mid-INIT at cnt=8 -> outputs clear immediately; INIT restarts at address 0 after release.
